// File: rtl/median_filter_pkg.sv
// Shared types and constants for the median filter read-side scheduler.
// Holds the scheduler state encoding, aux bit layout and the line-readiness helper.
package median_filter_pkg;

  localparam int DW_VX = 4;

  localparam int AUX_SOF = 0;
  localparam int AUX_EOL = 1;
  localparam int AUX_TOP = 2;
  localparam int AUX_BOT = 3;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_WAIT_LINES,
    RD_READ_LINE,
    RD_LINE_END,
    RD_FRAME_DONE
  } rd_state_t;

  // Lines that must be received before output row 'row' can be read: min(row+half+1, ih).
  function automatic logic [16:0] need_lines(input logic [15:0] row,
                                             input logic [15:0] half,
                                             input logic [15:0] ih);
    logic [16:0] want;
    want = {1'b0, row} + {1'b0, half} + 17'd1;
    return (want < {1'b0, ih}) ? want : {1'b0, ih};
  endfunction

endpackage

// File: rtl/median_filter_rd_sched_if.sv
// Master video bus carrying tagged line-stack columns to the median kernel.
// Valid/ready handshake; aux and data are held while valid is up and ready is low.
interface median_filter_rd_sched_if #(
  parameter int DW_DAT = 45,
  parameter int DW_AUX = 4
) ();
  logic              val;
  logic              rdy;
  logic [DW_AUX-1:0] aux;
  logic [DW_DAT-1:0] dat;

  modport master (output val, output aux, output dat, input rdy);
  modport slave  (input val, input aux, input dat, output rdy);
endinterface

// File: rtl/median_filter_skid.sv
// Small synchronous FIFO absorbing line-stack read latency in front of the output bus.
// Head data reads as zero while empty; pushes when full are dropped.
module median_filter_skid #(
  parameter int DEPTH = 3,
  parameter int W     = 19
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/median_filter_rd_sched.sv
// Read-side scheduler: waits for enough received lines, pops one line-stack column per
// credit, tags it with frame/line/border flags and forwards it through a skid FIFO.
module median_filter_rd_sched
  import median_filter_pkg::*;
#(
  parameter int SIZE    = 3,
  parameter int DW_FIFO = 15,
  parameter int DW_MD   = 16,
  parameter int RD_LAT  = 1,
  parameter int SKID    = RD_LAT + 2
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic [DW_MD-1:0]          iw,
  input  logic [DW_MD-1:0]          ih,
  input  logic [15:0]               rcvd_line_cntr,
  output logic [15:0]               sent_line_cntr,
  output logic                      line_stack_glb_rd_en,
  input  logic [SIZE*DW_FIFO-1:0]   line_stack_dout,
  median_filter_rd_sched_if.master  m_vb,
  output logic                      busy
);
  localparam int HALF = SIZE / 2;
  localparam int DW   = SIZE * DW_FIFO;
  localparam int W    = DW_VX + DW;
  localparam int CW   = $clog2(SKID + 1);
  localparam int IW   = $clog2(RD_LAT + 1);

  rd_state_t        state, state_n;
  logic [15:0]      row, row_n, col, col_n, sent_n;
  logic [DW_MD-1:0] iw_l, ih_l;
  logic [15:0]      iw16, ih16;
  logic             latch_cfg, rd_en;
  logic             credit, ready_now, ready_next, last_col, last_row;
  logic [7:0]       outstanding;
  logic [IW-1:0]    inflight;
  logic [RD_LAT-1:0] pipe_vld;
  logic [DW_VX-1:0] pipe_aux [RD_LAT];
  logic [DW_VX-1:0] tag_aux;

  logic          skid_push, skid_pop, skid_full, skid_empty;
  logic [W-1:0]  skid_din, skid_dout;
  logic [CW-1:0] skid_count;

  assign iw16        = 16'(iw_l);
  assign ih16        = 16'(ih_l);
  assign outstanding = 8'(skid_count) + 8'(inflight);
  assign credit      = outstanding < 8'(SKID);
  assign ready_now   = {1'b0, rcvd_line_cntr} >= need_lines(row, 16'(HALF), ih16);
  assign ready_next  = {1'b0, rcvd_line_cntr} >= need_lines(row + 16'd1, 16'(HALF), ih16);
  assign last_col    = (col == iw16 - 16'd1);
  assign last_row    = ({1'b0, row} + 17'd1 == {1'b0, ih16});
  assign busy        = (state != RD_IDLE);
  assign line_stack_glb_rd_en = rd_en;

  always_comb begin
    tag_aux          = '0;
    tag_aux[AUX_SOF] = (row == '0) && (col == '0);
    tag_aux[AUX_EOL] = last_col;
    tag_aux[AUX_TOP] = (row < 16'(HALF));
    tag_aux[AUX_BOT] = ({1'b0, row} + 17'(HALF) >= {1'b0, ih16});
  end

  always_comb begin
    state_n   = state;
    row_n     = row;
    col_n     = col;
    sent_n    = sent_line_cntr;
    rd_en     = 1'b0;
    latch_cfg = 1'b0;
    case (state)
      RD_IDLE: begin
        if (rcvd_line_cntr != '0 && iw != '0 && ih != '0) begin
          state_n   = RD_WAIT_LINES;
          latch_cfg = 1'b1;
          row_n     = '0;
        end
      end
      RD_WAIT_LINES: begin
        if (ready_now) begin
          state_n = RD_READ_LINE;
          col_n   = '0;
        end
      end
      RD_READ_LINE: begin
        if (credit) begin
          rd_en = 1'b1;
          col_n = col + 16'd1;
          if (last_col) state_n = RD_LINE_END;
        end
      end
      RD_LINE_END: begin
        sent_n = sent_line_cntr + 16'd1;
        row_n  = row + 16'd1;
        col_n  = '0;
        // Skip the WAIT_LINES visit when the next row is already ready: one bubble per line.
        if (last_row)        state_n = RD_FRAME_DONE;
        else if (ready_next) state_n = RD_READ_LINE;
        else                 state_n = RD_WAIT_LINES;
      end
      RD_FRAME_DONE: begin
        if (skid_empty && inflight == '0 && rcvd_line_cntr == '0) begin
          sent_n  = '0;
          row_n   = '0;
          state_n = RD_IDLE;
        end
      end
      default: state_n = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state          <= RD_IDLE;
      row            <= '0;
      col            <= '0;
      sent_line_cntr <= '0;
      iw_l           <= '0;
      ih_l           <= '0;
      inflight       <= '0;
      pipe_vld       <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) pipe_aux[i] <= '0;
    end else begin
      state          <= state_n;
      row            <= row_n;
      col            <= col_n;
      sent_line_cntr <= sent_n;
      if (latch_cfg) begin
        iw_l <= iw;
        ih_l <= ih;
      end
      inflight    <= inflight + IW'(rd_en) - IW'(pipe_vld[RD_LAT-1]);
      pipe_vld[0] <= rd_en;
      pipe_aux[0] <= tag_aux;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_aux[i] <= pipe_aux[i-1];
      end
    end
  end

  assign skid_push = pipe_vld[RD_LAT-1] && !skid_full;
  assign skid_din  = {pipe_aux[RD_LAT-1], line_stack_dout};
  assign skid_pop  = !skid_empty && m_vb.rdy;

  median_filter_skid #(.DEPTH(SKID), .W(W)) u_skid (
    .clk   (clk),
    .rstb  (rstb),
    .push  (skid_push),
    .pop   (skid_pop),
    .din   (skid_din),
    .dout  (skid_dout),
    .full  (skid_full),
    .empty (skid_empty),
    .count (skid_count)
  );

  assign m_vb.val = !skid_empty;
  assign m_vb.aux = skid_dout[W-1 -: DW_VX];
  assign m_vb.dat = skid_dout[DW-1:0];

endmodule

// File: tb/tb_median_filter_rd_sched.sv
// Bench for median_filter_rd_sched: two builds (RD_LAT 1 and 3) share the receive-side
// stimulus; a line-stack model feeds each, and a frame-level model checks every column.
module tb_median_filter_rd_sched;
  import median_filter_pkg::*;

  localparam int SIZE = 3, DW_FIFO = 15, DW = SIZE * DW_FIFO, HALF = SIZE / 2;
  localparam int LAT0 = 1, LAT1 = 3;

  logic clk = 1'b0;
  logic rstb = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] iw = '0, ih = '0, rcvd = '0;
  logic [1:0]  rdy_r = 2'b11;
  int          mode = 0, fid = 0;
  bit          chk_runs = 1'b0;

  logic [1:0]       rd_w, busy_w, val_w;
  logic [15:0]      sent_w [2];
  logic [DW-1:0]    dout_w [2];
  logic [DW_VX-1:0] aux_w  [2];
  logic [DW-1:0]    dat_w  [2];

  median_filter_rd_sched_if #(.DW_DAT(DW), .DW_AUX(DW_VX)) vb0 ();
  median_filter_rd_sched_if #(.DW_DAT(DW), .DW_AUX(DW_VX)) vb1 ();

  median_filter_rd_sched #(.SIZE(SIZE), .DW_FIFO(DW_FIFO), .DW_MD(16), .RD_LAT(LAT0)) dut0 (
    .clk(clk), .rstb(rstb), .iw(iw), .ih(ih), .rcvd_line_cntr(rcvd),
    .sent_line_cntr(sent_w[0]), .line_stack_glb_rd_en(rd_w[0]),
    .line_stack_dout(dout_w[0]), .m_vb(vb0), .busy(busy_w[0]));

  median_filter_rd_sched #(.SIZE(SIZE), .DW_FIFO(DW_FIFO), .DW_MD(16), .RD_LAT(LAT1)) dut1 (
    .clk(clk), .rstb(rstb), .iw(iw), .ih(ih), .rcvd_line_cntr(rcvd),
    .sent_line_cntr(sent_w[1]), .line_stack_glb_rd_en(rd_w[1]),
    .line_stack_dout(dout_w[1]), .m_vb(vb1), .busy(busy_w[1]));

  assign vb0.rdy  = rdy_r[0];
  assign vb1.rdy  = rdy_r[1];
  assign val_w[0] = vb0.val;
  assign val_w[1] = vb1.val;
  assign aux_w[0] = vb0.aux;
  assign aux_w[1] = vb1.aux;
  assign dat_w[0] = vb0.dat;
  assign dat_w[1] = vb1.dat;

  // Column content of frame f, output row r, column c: one lane per stacked line.
  function automatic logic [DW-1:0] pat(int f, int r, int c);
    logic [DW-1:0] v;
    for (int i = 0; i < SIZE; i++)
      v[i*DW_FIFO +: DW_FIFO] = 15'(((f & 7) << 12) | (((r + i) & 63) << 6) | (c & 63));
    return v;
  endfunction

  function automatic logic [DW_VX-1:0] exp_aux(int r, int c);
    logic [DW_VX-1:0] a;
    a          = '0;
    a[AUX_SOF] = (r == 0 && c == 0);
    a[AUX_EOL] = (c == int'(iw) - 1);
    a[AUX_TOP] = (r < HALF);
    a[AUX_BOT] = (r >= int'(ih) - HALF);
    return a;
  endfunction

  int total = 0, bad = 0;
  function automatic void chk(string name, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  // Line-stack model: the k-th read of a frame returns row k/iw, column k%iw, RD_LAT later.
  int            k_rd [2];
  logic [DW-1:0] ls0, ls1a, ls1b, ls1c;
  int            siw;
  assign siw       = (iw == 0) ? 1 : int'(iw);
  assign dout_w[0] = ls0;
  assign dout_w[1] = ls1c;
  always @(posedge clk) begin
    ls0  <= rd_w[0] ? pat(fid, k_rd[0] / siw, k_rd[0] % siw) : '1;
    ls1a <= rd_w[1] ? pat(fid, k_rd[1] / siw, k_rd[1] % siw) : '1;
    ls1b <= ls1a;
    ls1c <= ls1b;
    for (int d = 0; d < 2; d++) k_rd[d] <= busy_w[d] ? k_rd[d] + int'(rd_w[d]) : 0;
  end

  // Ready drivers: always high (0), toggling on dut0 (1) or random (2); dut1 random unless mode 0.
  initial forever begin
    @(posedge clk);
    #1;
    rdy_r[0] = (mode == 0) ? 1'b1 : (mode == 1) ? ~rdy_r[0] : 1'($urandom % 2);
    rdy_r[1] = (mode == 0) ? 1'b1 : 1'($urandom % 2);
  end

  int               out_k [2], issued [2], popped [2], rd_cnt [2], rd_life [2];
  int               n_sof, n_eol, n_top, n_bot, run, gap;
  bit               seen_run;
  bit               hold [2];
  logic [DW_VX-1:0] h_aux [2];
  logic [DW-1:0]    h_dat [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rstb) begin
        out_k[d] = 0; issued[d] = 0; popped[d] = 0; rd_cnt[d] = 0; hold[d] = 0;
        if (d == 0) begin n_sof = 0; n_eol = 0; n_top = 0; n_bot = 0; run = 0; gap = 0; seen_run = 0; end
      end else begin
        if (!busy_w[d]) begin
          out_k[d] = 0; rd_cnt[d] = 0;
          if (d == 0) begin n_sof = 0; n_eol = 0; n_top = 0; n_bot = 0; run = 0; gap = 0; seen_run = 0; end
        end
        if (hold[d]) begin
          chk($sformatf("stall_val%0d", d), longint'(val_w[d]), 1);
          chk($sformatf("stall_aux%0d", d), longint'(aux_w[d]), longint'(h_aux[d]));
          chk($sformatf("stall_dat%0d", d), longint'(dat_w[d]), longint'(h_dat[d]));
        end
        if (rd_w[d]) begin
          chk($sformatf("credit%0d", d), longint'(issued[d] - popped[d] < (d == 0 ? LAT0 + 2 : LAT1 + 2)), 1);
          issued[d]++; rd_cnt[d]++; rd_life[d]++;
        end
        if (val_w[d] && rdy_r[d]) begin
          chk($sformatf("extra_col%0d", d), longint'(out_k[d] < int'(iw) * int'(ih)), 1);
          chk($sformatf("aux%0d_k%0d", d, out_k[d]), longint'(aux_w[d]),
              longint'(exp_aux(out_k[d] / siw, out_k[d] % siw)));
          chk($sformatf("dat%0d_k%0d", d, out_k[d]), longint'(dat_w[d]),
              longint'(pat(fid, out_k[d] / siw, out_k[d] % siw)));
          if (d == 0) begin
            n_sof += int'(aux_w[0][AUX_SOF]); n_eol += int'(aux_w[0][AUX_EOL]);
            n_top += int'(aux_w[0][AUX_TOP]); n_bot += int'(aux_w[0][AUX_BOT]);
          end
          out_k[d]++; popped[d]++;
        end
        hold[d]  = val_w[d] && !rdy_r[d];
        h_aux[d] = aux_w[d];
        h_dat[d] = dat_w[d];
        if (d == 0) begin
          if (rd_w[0]) begin
            if (run == 0 && seen_run && chk_runs) chk("line_gap", gap, 1);
            run++; gap = 0;
          end else begin
            if (run > 0) begin
              if (chk_runs) chk("rd_run", run, int'(iw));
              run = 0; seen_run = 1;
            end
            gap++;
          end
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cols(int cols);
    int n = 0;
    while ((out_k[0] != cols || out_k[1] != cols) && n < 20000) begin tick(1); n++; end
    chk("cols0", out_k[0], cols);
    chk("cols1", out_k[1], cols);
  endtask

  task automatic finish_frame(int lines);
    int n = 0;
    tick(2);
    chk("sent0_end", sent_w[0], lines);
    chk("sent1_end", sent_w[1], lines);
    chk("busy_hold", busy_w[0], 1);
    rcvd = '0;
    while (busy_w != 2'b00 && n < 200) begin tick(1); n++; end
    chk("idle0", busy_w[0], 0);
    chk("idle1", busy_w[1], 0);
    chk("sent0_clr", sent_w[0], 0);
    chk("sent1_clr", sent_w[1], 0);
  endtask

  task automatic run_frame(int w, int h, int m, int tops, int bots);
    fid++; mode = m; iw = 16'(w); ih = 16'(h); chk_runs = (m == 0);
    rcvd = 16'(h);
    wait_cols(w * h);
    chk("n_sof", n_sof, 1);
    chk("n_eol", n_eol, h);
    chk("n_top", n_top, tops);
    chk("n_bot", n_bot, bots);
    chk_runs = 1'b0;
    finish_frame(h);
  endtask

  typedef struct { int w; int h; int m; int tops; int bots; } vec_t;
  vec_t tbl [5];
  int   snap0, snap1, n;

  initial begin
    tbl[0] = '{w: 16, h: 8, m: 0, tops: 16, bots: 16};
    tbl[1] = '{w: 4,  h: 3, m: 1, tops: 4,  bots: 4};
    tbl[2] = '{w: 5,  h: 5, m: 2, tops: 5,  bots: 5};
    tbl[3] = '{w: 1,  h: 1, m: 2, tops: 1,  bots: 1};
    tbl[4] = '{w: 3,  h: 2, m: 0, tops: 3,  bots: 3};

    #1 rstb = 1'b0;
    tick(3);
    chk("rst_rd", rd_w[0], 0);
    chk("rst_val", val_w[0], 0);
    chk("rst_aux", aux_w[0], 0);
    chk("rst_dat", dat_w[0], 0);
    chk("rst_busy", busy_w, 0);
    chk("rst_sent", sent_w[0], 0);
    rstb = 1'b1;
    tick(2);

    // Stepped receive counter on a 4x3 frame.
    fid++; mode = 0; iw = 16'd4; ih = 16'd3; rcvd = 16'd1;
    tick(10);
    chk("step_busy", busy_w, 2'b11);
    chk("step_no_rd0", rd_cnt[0], 0);
    chk("step_no_rd1", rd_cnt[1], 0);
    rcvd = 16'd2;
    tick(15);
    chk("step_row0_rd0", rd_cnt[0], 4);
    chk("step_row0_rd1", rd_cnt[1], 4);
    chk("step_sent1", sent_w[0], 1);
    rcvd = 16'd3;
    wait_cols(12);
    chk("step_sof", n_sof, 1);
    chk("step_eol", n_eol, 3);
    chk("step_top", n_top, 4);
    chk("step_bot", n_bot, 4);
    tick(10);
    chk("step_done_hold", busy_w[0], 1);
    finish_frame(3);

    // Zero width never starts a frame.
    fid++; iw = '0; ih = 16'd4; rcvd = 16'd1;
    snap0 = rd_life[0]; snap1 = rd_life[1];
    tick(10);
    chk("iw0_busy", busy_w, 0);
    chk("iw0_rd0", rd_life[0] - snap0, 0);
    chk("iw0_rd1", rd_life[1] - snap1, 0);
    rcvd = '0;
    tick(2);

    for (int i = 0; i < 5; i++) run_frame(tbl[i].w, tbl[i].h, tbl[i].m, tbl[i].tops, tbl[i].bots);

    // Reset in the middle of row 1 of an 8x8 frame, then a clean frame.
    fid++; mode = 0; iw = 16'd8; ih = 16'd8; rcvd = 16'd8;
    n = 0;
    while (sent_w[0] != 16'd1 && n < 500) begin tick(1); n++; end
    chk("mid_reach_row1", sent_w[0], 1);
    tick(3);
    rstb = 1'b0;
    #1;
    chk("mid_rd", rd_w, 0);
    chk("mid_val", val_w, 0);
    chk("mid_aux", aux_w[0], 0);
    chk("mid_dat", dat_w[0], 0);
    chk("mid_busy", busy_w, 0);
    chk("mid_sent", sent_w[0], 0);
    rcvd = '0;
    tick(2);
    rstb = 1'b1;
    tick(2);
    run_frame(8, 8, 0, 8, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
